// File: rtl/ysyx_2022040010_mem.sv
// Memory-access pipeline stage between EX and WB.
// Latches the EX->MEM bus, runs one load/store on the data-memory port with a
// valid/ready handshake, aligns store data/masks, extends load data, and emits
// the MEM->WB bus plus the MEM-stage bypass to ID.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   stall[5:0]        : pipeline stall vector, stall[2] holds this stage
//   ex_to_mem_bus     : EX->MEM payload (334 bits)
//   mem_to_wb_bus     : MEM->WB payload (265 bits), zero when not valid
//   mem_to_rf_bus     : {we, waddr, wdata} bypass to ID
//   stallreq_mem      : hold upstream while a transaction is outstanding
//   dmem_*            : data-memory request/response port
module ysyx_2022040010_mem #(
  parameter  int unsigned EX_TO_MEM_WD = 334,
  parameter  int unsigned MEM_TO_WB_WD = 265,
  localparam int unsigned XLEN         = 64,
  localparam int unsigned RF_BUS_WD    = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [RF_BUS_WD-1:0]    mem_to_rf_bus,
  output logic                    stallreq_mem,
  output logic                    dmem_req,
  output logic                    dmem_wen,
  output logic [XLEN-1:0]         dmem_addr,
  output logic [XLEN-1:0]         dmem_wdata,
  output logic [7:0]              dmem_wmask,
  input  logic                    dmem_ready,
  input  logic                    dmem_rvalid,
  input  logic [XLEN-1:0]         dmem_rdata
);

  typedef struct packed {
    logic [1:0]      sp_bus;
    logic            op_sp;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] inst;
    logic            mem_re;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] store_data;
  } ex_to_mem_t;

  typedef struct packed {
    logic [1:0]      sp_bus;
    logic            op_sp;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [XLEN-1:0] inst;
  } mem_to_wb_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  ex_to_mem_t      r_ex;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_load;

  ex_to_mem_t      w_ex_in;
  logic            w_load_en;
  logic            w_in_memop;
  logic            w_memop;
  logic            w_valid;
  logic [2:0]      w_off;
  logic [5:0]      w_shamt;
  logic [7:0]      w_base_mask;
  logic [XLEN-1:0] w_ld_shift;
  logic [XLEN-1:0] w_ld_ext;
  logic            w_ld_sign;
  logic [XLEN-1:0] w_rf_wdata;
  mem_to_wb_t      w_wb;
  logic            w_unused_stall;

  assign w_ex_in    = ex_to_mem_t'(ex_to_mem_bus);
  assign w_load_en  = ~stall[2];
  assign w_in_memop = (w_ex_in.pc != '0) & (w_ex_in.mem_re | w_ex_in.mem_we);
  assign w_memop    = (r_ex.pc != '0) & (r_ex.mem_re | r_ex.mem_we);
  assign w_off      = r_ex.alu_result[2:0];
  assign w_shamt    = {w_off, 3'b000};

  // Only stall[2] belongs to this stage.
  assign w_unused_stall = ^{stall[5:3], stall[1:0]};

  // Input register: holds under stall[2], otherwise follows EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex <= '0;
    end else if (w_load_en) begin
      r_ex <= w_ex_in;
    end
  end

  // Raw load word; extension is applied on the output side using the latched offset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load <= '0;
    end else if ((r_state == S_WAIT) && dmem_rvalid) begin
      r_load <= dmem_rdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a register reload always restarts the stage.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load_en) begin
      w_state_nxt = w_in_memop ? S_REQ : S_IDLE;
    end else begin
      case (r_state)
        S_REQ:   if (dmem_ready)  w_state_nxt = r_ex.mem_we ? S_DONE : S_WAIT;
        S_WAIT:  if (dmem_rvalid) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Byte-lane mask before shifting to the access offset.
  always_comb begin
    w_base_mask = 8'h01;
    case (r_ex.mem_size)
      2'd0:    w_base_mask = 8'h01;
      2'd1:    w_base_mask = 8'h03;
      2'd2:    w_base_mask = 8'h0F;
      default: w_base_mask = 8'hFF;
    endcase
  end

  // Memory port; the mask is only asserted while a request is live.
  assign dmem_req     = (r_state == S_REQ);
  assign dmem_wen     = r_ex.mem_we;
  assign dmem_addr    = {r_ex.alu_result[XLEN-1:3], 3'b000};
  assign dmem_wdata   = r_ex.store_data << w_shamt;
  assign dmem_wmask   = (r_state == S_REQ) ? 8'(w_base_mask << w_off) : 8'h00;
  assign stallreq_mem = (r_state == S_REQ) | (r_state == S_WAIT);

  // Load alignment and sign/zero extension.
  always_comb begin
    w_ld_shift = r_load >> w_shamt;
    w_ld_sign  = 1'b0;
    w_ld_ext   = w_ld_shift;
    case (r_ex.mem_size)
      2'd0: begin
        w_ld_sign = ~r_ex.mem_unsigned & w_ld_shift[7];
        w_ld_ext  = {{56{w_ld_sign}}, w_ld_shift[7:0]};
      end
      2'd1: begin
        w_ld_sign = ~r_ex.mem_unsigned & w_ld_shift[15];
        w_ld_ext  = {{48{w_ld_sign}}, w_ld_shift[15:0]};
      end
      2'd2: begin
        w_ld_sign = ~r_ex.mem_unsigned & w_ld_shift[31];
        w_ld_ext  = {{32{w_ld_sign}}, w_ld_shift[31:0]};
      end
      default: w_ld_ext = w_ld_shift;
    endcase
  end

  assign w_rf_wdata = r_ex.mem_re ? w_ld_ext : r_ex.alu_result;
  assign w_valid    = ~w_memop | (r_state == S_DONE);

  // WB payload; an all-zero bus is a bubble.
  always_comb begin
    w_wb = '0;
    if (w_valid) begin
      w_wb.sp_bus   = r_ex.sp_bus;
      w_wb.op_sp    = r_ex.op_sp;
      w_wb.next_pc  = r_ex.next_pc;
      w_wb.pc       = r_ex.pc;
      w_wb.rf_we    = r_ex.rf_we;
      w_wb.rf_waddr = r_ex.rf_waddr;
      w_wb.rf_wdata = w_rf_wdata;
      w_wb.inst     = r_ex.inst;
    end
  end

  assign mem_to_wb_bus = w_wb;
  assign mem_to_rf_bus = {r_ex.rf_we & w_valid & (r_ex.rf_waddr != 5'd0),
                          r_ex.rf_waddr, w_rf_wdata};

endmodule

// File: tb/tb_ysyx_2022040010_mem.sv
// Self-checking bench for ysyx_2022040010_mem: directed scenarios plus
// randomized loads/stores/ALU ops against a byte-level reference model.
module tb_ysyx_2022040010_mem;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   stall = '0;
  logic [333:0] ex_to_mem_bus = '0;
  logic [264:0] mem_to_wb_bus;
  logic [69:0]  mem_to_rf_bus;
  logic         stallreq_mem;
  logic         dmem_req;
  logic         dmem_wen;
  logic [63:0]  dmem_addr;
  logic [63:0]  dmem_wdata;
  logic [7:0]   dmem_wmask;
  logic         dmem_ready = 1'b0;
  logic         dmem_rvalid = 1'b0;
  logic [63:0]  dmem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_2022040010_mem dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .ex_to_mem_bus (ex_to_mem_bus),
    .mem_to_wb_bus (mem_to_wb_bus),
    .mem_to_rf_bus (mem_to_rf_bus),
    .stallreq_mem  (stallreq_mem),
    .dmem_req      (dmem_req),
    .dmem_wen      (dmem_wen),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wmask    (dmem_wmask),
    .dmem_ready    (dmem_ready),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] inst_of(logic [63:0] pc);
    return {32'h0, pc[31:0] ^ 32'h0000_0013};
  endfunction

  function automatic logic [333:0] pack_ex(logic [63:0] pc, logic rf_we, logic [4:0] wa,
                                           logic [63:0] alu, logic re, logic we,
                                           logic [1:0] sz, logic uns, logic [63:0] sd);
    return {pc[3:2], pc[4], pc + 64'd4, pc, rf_we, wa, alu, inst_of(pc), re, we, sz, uns, sd};
  endfunction

  function automatic logic [264:0] pack_wb(logic [63:0] pc, logic rf_we, logic [4:0] wa,
                                           logic [63:0] wdata);
    return {pc[3:2], pc[4], pc + 64'd4, pc, rf_we, wa, wdata, inst_of(pc)};
  endfunction

  function automatic logic [7:0] model_mask(logic [2:0] off, logic [1:0] sz);
    logic [7:0] m;
    int n;
    m = '0;
    n = 1 << int'(sz);
    for (int i = 0; i < 8; i++)
      if (i >= int'(off) && i < int'(off) + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(logic [2:0] off, logic [63:0] sd);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off)) w[8*i +: 8] = sd[8*(i - int'(off)) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(logic [63:0] word, logic [2:0] off,
                                             logic [1:0] sz, logic uns);
    logic [63:0] v;
    int n;
    v = '0;
    n = 1 << int'(sz);
    for (int k = 0; k < n; k++)
      if (int'(off) + k < 8) v[8*k +: 8] = word[8*(int'(off) + k) +: 8];
    if (!uns && n < 8 && v[8*n - 1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  // One transaction: load the op, play the memory side, check timing and result,
  // then optionally hold the stage with stall[2] and check the result repeats.
  task automatic run_op(input string name, input logic [63:0] pc, input logic rf_we,
                        input logic [4:0] wa, input logic [63:0] alu, input logic re,
                        input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] sd, input logic [63:0] rdata,
                        input int rdy_wait, input int rv_wait, input bit stray,
                        input int hold);
    logic          memop;
    int            exp_stall;
    logic [63:0]   exp_wd;
    logic [264:0]  exp_wb;
    logic [69:0]   exp_rf;
    int            req_cnt;
    int            wait_cnt;
    int            stall_cnt;
    int            cyc;
    memop     = (pc != 0) && (re || we);
    exp_stall = memop ? (1 + rdy_wait + (re ? 1 + rv_wait : 0)) : 0;
    exp_wd    = re ? model_load(rdata, alu[2:0], sz, uns) : alu;
    exp_wb    = pack_wb(pc, rf_we, wa, exp_wd);
    exp_rf    = {rf_we && (wa != 0), wa, exp_wd};

    stall         = '0;
    dmem_ready    = 1'b0;
    dmem_rvalid   = 1'b0;
    ex_to_mem_bus = pack_ex(pc, rf_we, wa, alu, re, we, sz, uns, sd);
    @(posedge clk); #1;
    ex_to_mem_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom[13:0]};

    req_cnt = 0; wait_cnt = 0; stall_cnt = 0; cyc = 0;
    while (stallreq_mem === 1'b1 && cyc < 60) begin
      stall_cnt++;
      stall = {3'($urandom), 1'b1, 2'($urandom)};
      n_checks++;
      if (mem_to_wb_bus !== '0 || mem_to_rf_bus[69] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s bubble: wb=%h rf_we=%b required wb=0 rf_we=0",
                 name, mem_to_wb_bus, mem_to_rf_bus[69]);
      end
      if (dmem_req === 1'b1) begin
        n_checks++;
        if (dmem_wen !== we || dmem_addr !== {alu[63:3], 3'b000} ||
            dmem_wmask !== model_mask(alu[2:0], sz) || dmem_wdata !== model_wdata(alu[2:0], sd)) begin
          n_fail++;
          $display("FAIL %s req: wen=%b addr=%h mask=%h wdata=%h required wen=%b addr=%h mask=%h wdata=%h",
                   name, dmem_wen, dmem_addr, dmem_wmask, dmem_wdata, we, {alu[63:3], 3'b000},
                   model_mask(alu[2:0], sz), model_wdata(alu[2:0], sd));
        end
        dmem_ready  = (req_cnt >= rdy_wait);
        dmem_rvalid = stray;
        dmem_rdata  = {$urandom, $urandom};
        req_cnt++;
      end else begin
        dmem_ready  = 1'($urandom);
        dmem_rvalid = (wait_cnt >= rv_wait);
        dmem_rdata  = dmem_rvalid ? rdata : {$urandom, $urandom};
        wait_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;

    n_checks++;
    if (cyc >= 60) begin
      n_fail++;
      $display("FAIL %s timeout: stall cycles=%0d required=%0d", name, stall_cnt, exp_stall);
    end else if (stall_cnt != exp_stall) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d required %0d", name, stall_cnt, exp_stall);
    end

    for (int h = 0; h <= hold; h++) begin
      n_checks++;
      if (mem_to_wb_bus !== exp_wb || mem_to_rf_bus !== exp_rf ||
          stallreq_mem !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL %s result[%0d]: wb=%h rf=%h sreq=%b req=%b required wb=%h rf=%h sreq=0 req=0",
                 name, h, mem_to_wb_bus, mem_to_rf_bus, stallreq_mem, dmem_req, exp_wb, exp_rf);
      end
      if (h < hold) begin
        stall       = 6'b000100;
        dmem_rvalid = 1'($urandom);
        dmem_rdata  = {$urandom, $urandom};
        @(posedge clk); #1;
      end
    end
    stall       = '0;
    dmem_rvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst           = 1'b0;
    ex_to_mem_bus = pack_ex(64'h8000_0000, 1'b1, 5'd3, 64'h8000_0010, 1'b1, 1'b0, 2'd3, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0 || stallreq_mem !== 1'b0 ||
        dmem_req !== 1'b0 || dmem_wmask !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: wb=%h rf=%h sreq=%b req=%b mask=%h required all zero",
               mem_to_wb_bus, mem_to_rf_bus, stallreq_mem, dmem_req, dmem_wmask);
    end
    ex_to_mem_bus = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    stall         = '0;
    dmem_ready    = 1'b0;
    ex_to_mem_bus = pack_ex(64'h8000_0100, 1'b0, 5'd0, 64'h8000_4000, 1'b0, 1'b1, 2'd3, 1'b0, 64'h1122);
    @(posedge clk); #1;
    stall = 6'b000100;
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre: dmem_req=%b required 1", dmem_req);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || stallreq_mem !== 1'b0 || mem_to_wb_bus !== '0 ||
        mem_to_rf_bus !== '0 || dmem_wmask !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid async: req=%b sreq=%b wb=%h rf=%h mask=%h required all zero",
               dmem_req, stallreq_mem, mem_to_wb_bus, mem_to_rf_bus, dmem_wmask);
    end
    ex_to_mem_bus = '0;
    stall         = '0;
    dmem_rvalid   = 1'b1;
    dmem_rdata    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (stallreq_mem !== 1'b0 || dmem_req !== 1'b0 || mem_to_wb_bus !== '0) begin
      n_fail++;
      $display("FAIL reset_mid idle: sreq=%b req=%b wb=%h required 0 0 0",
               stallreq_mem, dmem_req, mem_to_wb_bus);
    end
    dmem_rvalid = 1'b0;
  endtask

  task automatic test_alu();
    run_op("alu", 64'h8000_0000, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0, 2'd0, 1'b0,
           64'h0, 64'h0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_store_sh();
    run_op("store_sh", 64'h8000_0004, 1'b0, 5'd0, 64'h8000_1006, 1'b0, 1'b1, 2'd1, 1'b0,
           64'hBEEF, 64'h0, 2, 0, 1'b0, 0);
  endtask

  task automatic test_load_byte();
    run_op("load_lb", 64'h8000_0008, 1'b1, 5'd10, 64'h8000_2003, 1'b1, 1'b0, 2'd0, 1'b0,
           64'h0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 0);
    run_op("load_lbu", 64'h8000_000C, 1'b1, 5'd11, 64'h8000_2003, 1'b1, 1'b0, 2'd0, 1'b1,
           64'h0, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 0);
  endtask

  task automatic test_load_word_delayed();
    run_op("load_lw", 64'h8000_0010, 1'b1, 5'd12, 64'h8000_3004, 1'b1, 1'b0, 2'd2, 1'b0,
           64'h0, 64'h8000_0001_DEAD_BEEF, 1, 3, 1'b1, 0);
  endtask

  task automatic test_zero_waddr();
    run_op("load_x0", 64'h8000_0014, 1'b1, 5'd0, 64'h8000_3000, 1'b1, 1'b0, 2'd3, 1'b0,
           64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 1'b0, 0);
  endtask

  task automatic test_hold();
    run_op("hold_store", 64'h8000_0018, 1'b1, 5'd7, 64'h8000_5005, 1'b0, 1'b1, 2'd2, 1'b0,
           64'hCAFE_F00D, 64'h0, 0, 0, 1'b0, 4);
    run_op("hold_load", 64'h8000_001C, 1'b1, 5'd8, 64'h8000_5002, 1'b1, 1'b0, 2'd1, 1'b0,
           64'h0, 64'h0000_0000_9876_0000, 1, 2, 1'b1, 3);
    run_op("hold_alu", 64'h8000_0020, 1'b1, 5'd9, 64'hABCD, 1'b0, 1'b0, 2'd0, 1'b0,
           64'h0, 64'h0, 0, 0, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      int          kind;
      logic [63:0] pc;
      kind = int'($urandom_range(0, 2));
      pc   = {32'h0, 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC)};
      run_op("random", pc, 1'($urandom), 5'($urandom), {$urandom, $urandom},
             kind == 1, kind == 2, 2'($urandom), 1'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom), ($urandom_range(0, 4) == 0) ? 2 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_sh();
    test_load_byte();
    test_load_word_delayed();
    test_zero_waddr();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
